// File: rtl/line_generator_v2_if.sv
// Command and pixel stream bundle for the line rasteriser; master is the parent,
// slave is the generator.
interface line_generator_v2_if #(
    parameter int COORD_W = 12
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic signed [COORD_W-1:0] aX;
    logic signed [COORD_W-1:0] aY;
    logic signed [COORD_W-1:0] bX;
    logic signed [COORD_W-1:0] bY;
    logic                      stop_y_ena;
    logic                      resume;
    logic                      abort;
    logic                      pix_valid;
    logic                      pix_ready;
    logic signed [COORD_W-1:0] X_coord;
    logic signed [COORD_W-1:0] Y_coord;
    logic                      busy;
    logic                      ypos_stopped;
    logic                      line_complete;

    modport master (
        output cmd_valid, aX, aY, bX, bY, stop_y_ena, resume, abort, pix_ready,
        input  cmd_ready, pix_valid, X_coord, Y_coord, busy, ypos_stopped, line_complete
    );

    modport slave (
        input  cmd_valid, aX, aY, bX, bY, stop_y_ena, resume, abort, pix_ready,
        output cmd_ready, pix_valid, X_coord, Y_coord, busy, ypos_stopped, line_complete
    );
endinterface

// File: rtl/line_generator_v2.sv
// Bresenham line rasteriser: accepts a line command, emits one signed pixel per
// accepted beat, optionally pauses on every Y change, and can be aborted.
module line_generator_v2 #(
    parameter int COORD_W   = 12,
    parameter bit STOP_Y_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    line_generator_v2_if.slave bus
);
    localparam int DW = COORD_W + 1;
    localparam int EW = COORD_W + 2;

    typedef enum logic [2:0] {IDLE, SETUP, DRAW, PAUSE, DONE} state_t;

    state_t                    state_reg, state_next;
    logic signed [COORD_W-1:0] x_reg, x_next;
    logic signed [COORD_W-1:0] y_reg, y_next;
    logic signed [COORD_W-1:0] bx_reg, bx_next;
    logic signed [COORD_W-1:0] by_reg, by_next;
    logic signed [DW-1:0]      dx_reg, dx_next;
    logic signed [DW-1:0]      dy_reg, dy_next;
    logic signed [1:0]         sx_reg, sx_next;
    logic signed [1:0]         sy_reg, sy_next;
    logic signed [EW-1:0]      err_reg, err_next;
    logic                      stop_reg, stop_next;

    logic signed [DW-1:0]      delta_x, delta_y, abs_x, abs_y;
    logic signed [EW-1:0]      e2, dx_ext, dy_ext;
    logic                      step_x, step_y, at_end, y_changes;

    // Deltas are one bit wider than coordinates so full-range lines cannot wrap.
    always_comb begin
        delta_x   = DW'(bx_reg) - DW'(x_reg);
        delta_y   = DW'(by_reg) - DW'(y_reg);
        abs_x     = delta_x[DW-1] ? -delta_x : delta_x;
        abs_y     = delta_y[DW-1] ? -delta_y : delta_y;
        dx_ext    = EW'(dx_reg);
        dy_ext    = EW'(dy_reg);
        e2        = err_reg <<< 1;
        step_x    = (e2 >= dy_ext);
        step_y    = (e2 <= dx_ext);
        at_end    = (x_reg == bx_reg) && (y_reg == by_reg);
        y_changes = step_y && (sy_reg != 2'sb00);
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        bx_next    = bx_reg;
        by_next    = by_reg;
        dx_next    = dx_reg;
        dy_next    = dy_reg;
        sx_next    = sx_reg;
        sy_next    = sy_reg;
        err_next   = err_reg;
        stop_next  = stop_reg;

        if (bus.abort && state_reg != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state_next = SETUP;
                        x_next     = bus.aX;
                        y_next     = bus.aY;
                        bx_next    = bus.bX;
                        by_next    = bus.bY;
                        stop_next  = bus.stop_y_ena;
                    end
                end
                SETUP: begin
                    sx_next    = delta_x[DW-1] ? 2'sb11 : ((delta_x != '0) ? 2'sb01 : 2'sb00);
                    sy_next    = delta_y[DW-1] ? 2'sb11 : ((delta_y != '0) ? 2'sb01 : 2'sb00);
                    dx_next    = abs_x;
                    dy_next    = -abs_y;
                    err_next   = EW'(abs_x) - EW'(abs_y);
                    state_next = DRAW;
                end
                DRAW: begin
                    if (bus.pix_ready) begin
                        if (at_end) begin
                            state_next = DONE;
                        end else begin
                            // Both axis steps share one summed error update.
                            err_next = err_reg + (step_x ? dy_ext : '0) + (step_y ? dx_ext : '0);
                            x_next   = x_reg + (step_x ? COORD_W'(sx_reg) : '0);
                            y_next   = y_reg + (step_y ? COORD_W'(sy_reg) : '0);
                            if (STOP_Y_EN && stop_reg && y_changes) begin
                                state_next = PAUSE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.resume) begin
                        state_next = DRAW;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            bx_reg    <= '0;
            by_reg    <= '0;
            dx_reg    <= '0;
            dy_reg    <= '0;
            sx_reg    <= '0;
            sy_reg    <= '0;
            err_reg   <= '0;
            stop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            bx_reg    <= bx_next;
            by_reg    <= by_next;
            dx_reg    <= dx_next;
            dy_reg    <= dy_next;
            sx_reg    <= sx_next;
            sy_reg    <= sy_next;
            err_reg   <= err_next;
            stop_reg  <= stop_next;
        end
    end

    assign bus.cmd_ready     = (state_reg == IDLE);
    assign bus.busy          = (state_reg != IDLE);
    assign bus.pix_valid     = (state_reg == DRAW);
    assign bus.X_coord       = x_reg;
    assign bus.Y_coord       = y_reg;
    assign bus.line_complete = (state_reg == DONE);
    assign bus.ypos_stopped  = STOP_Y_EN && (state_reg == PAUSE);
endmodule
